// File: rtl/apb_periph_fabric_pkg.sv
// Shared types and constants for the LINT-to-APB peripheral fabric.
// Holds the bridge FSM encoding, the unmapped-access read pattern and a clog2 helper.
package apb_periph_fabric_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } fab_state_e;

   localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

   // Ceiling log2, never below 1 so single-slave builds still get a 1-bit index.
   function automatic int clog2_min1(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 << i) < n) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: checks the fabric base region and extracts the slave index.
module apb_addr_decoder #(
   parameter int                    NUM_SLAVES      = 4,
   parameter int                    ADDR_WIDTH      = 32,
   parameter int                    SLAVE_ADDR_BITS = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h1A10_0000,
   parameter int                    IDXW            = 2
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  hit,
   output logic [IDXW-1:0]       index
);

   localparam int              HI_BIT  = SLAVE_ADDR_BITS + IDXW;
   localparam logic [IDXW:0]   NUM_S_L = (IDXW + 1)'(NUM_SLAVES);

   // Region match on the bits above the index field, then range-check the index.
   always_comb begin
      index = addr[SLAVE_ADDR_BITS +: IDXW];
      hit   = ((addr >> HI_BIT) == (BASE_ADDR >> HI_BIT)) && ({1'b0, index} < NUM_S_L);
   end

endmodule

// File: rtl/apb_periph_fabric.sv
// LINT request port bridged to NUM_SLAVES APB slaves with address decode,
// ACCESS-phase timeout and a fixed error response for unmapped addresses.
module apb_periph_fabric
   import apb_periph_fabric_pkg::*;
#(
   parameter int                    NUM_SLAVES      = 4,
   parameter int                    ADDR_WIDTH      = 32,
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    SLAVE_ADDR_BITS = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h1A10_0000,
   parameter int                    TIMEOUT_CYCLES  = 255,
   localparam int                   BE_WIDTH        = DATA_WIDTH / 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             peri_req,
   input  logic [ADDR_WIDTH-1:0]            peri_addr,
   input  logic                             peri_write,
   input  logic [BE_WIDTH-1:0]              peri_be,
   input  logic [DATA_WIDTH-1:0]            peri_wdata,
   output logic                             peri_gnt,
   output logic                             peri_rvalid,
   output logic [DATA_WIDTH-1:0]            peri_rdata,
   output logic                             peri_err,
   output logic [ADDR_WIDTH-1:0]            apb_paddr,
   output logic [DATA_WIDTH-1:0]            apb_pwdata,
   output logic                             apb_pwrite,
   output logic [BE_WIDTH-1:0]              apb_pstrb,
   output logic                             apb_penable,
   output logic [NUM_SLAVES-1:0]            apb_psel,
   input  logic [NUM_SLAVES-1:0]            apb_pready,
   input  logic [NUM_SLAVES-1:0]            apb_pslverr,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] apb_prdata
);

   localparam int                    IDXW       = clog2_min1(NUM_SLAVES);
   localparam int                    CNT_W      = clog2_min1(TIMEOUT_CYCLES + 1) + 1;
   localparam logic [DATA_WIDTH-1:0] ERR_DATA_L = DATA_WIDTH'(ERR_RDATA);

   fab_state_e                state_r, next_s;
   logic                      dec_hit_s;
   logic [IDXW-1:0]           dec_idx_s;
   logic [IDXW-1:0]           index_r;
   logic [ADDR_WIDTH-1:0]     addr_r;
   logic [DATA_WIDTH-1:0]     wdata_r;
   logic [BE_WIDTH-1:0]       pstrb_r;
   logic                      pwrite_r;
   logic [CNT_W-1:0]          cnt_r, cnt_nx_s, cnt_inc_s;
   logic                      timeout_s;
   logic                      latch_s;
   logic [NUM_SLAVES-1:0]     psel_r, psel_nx_s;
   logic                      penable_r, penable_nx_s;
   logic                      rvalid_r, rvalid_nx_s;
   logic                      err_r, err_nx_s;
   logic [DATA_WIDTH-1:0]     rdata_r, rdata_nx_s;
   logic                      sel_ready_s, sel_err_s;
   logic [DATA_WIDTH-1:0]     sel_rdata_s;

   apb_addr_decoder #(
      .NUM_SLAVES      (NUM_SLAVES),
      .ADDR_WIDTH      (ADDR_WIDTH),
      .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS),
      .BASE_ADDR       (BASE_ADDR),
      .IDXW            (IDXW)
   ) u_dec (
      .addr  (peri_addr),
      .hit   (dec_hit_s),
      .index (dec_idx_s)
   );

   // Response mux: only the slave matching the latched index is ever observed.
   always_comb begin
      sel_ready_s = 1'b0;
      sel_err_s   = 1'b0;
      sel_rdata_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (index_r == IDXW'(i)) begin
            sel_ready_s = apb_pready[i];
            sel_err_s   = apb_pslverr[i];
            sel_rdata_s = apb_prdata[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            sel_ready_s = sel_ready_s;
         end
      end
   end

   assign cnt_inc_s = cnt_r + CNT_W'(1);
   assign timeout_s = (TIMEOUT_CYCLES != 0) && (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES));
   assign peri_gnt  = (state_r == ST_IDLE) && peri_req;

   // Next-state and next-output logic; outputs are registered one cycle ahead.
   always_comb begin
      next_s       = state_r;
      psel_nx_s    = psel_r;
      penable_nx_s = 1'b0;
      rvalid_nx_s  = 1'b0;
      err_nx_s     = 1'b0;
      rdata_nx_s   = {DATA_WIDTH{1'b0}};
      cnt_nx_s     = cnt_r;
      latch_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            psel_nx_s = {NUM_SLAVES{1'b0}};
            if (peri_req) begin
               latch_s  = 1'b1;
               cnt_nx_s = {CNT_W{1'b0}};
               if (dec_hit_s) begin
                  next_s    = ST_SETUP;
                  psel_nx_s = NUM_SLAVES'(1'b1) << dec_idx_s;
               end else begin
                  next_s      = ST_RESP;
                  rvalid_nx_s = 1'b1;
                  err_nx_s    = 1'b1;
                  rdata_nx_s  = ERR_DATA_L;
               end
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            next_s       = ST_ACCESS;
            penable_nx_s = 1'b1;
         end
         ST_ACCESS: begin
            if (sel_ready_s) begin
               next_s      = ST_RESP;
               psel_nx_s   = {NUM_SLAVES{1'b0}};
               rvalid_nx_s = 1'b1;
               err_nx_s    = sel_err_s;
               rdata_nx_s  = (!pwrite_r && !sel_err_s) ? sel_rdata_s : {DATA_WIDTH{1'b0}};
            end else if (timeout_s) begin
               next_s      = ST_RESP;
               psel_nx_s   = {NUM_SLAVES{1'b0}};
               rvalid_nx_s = 1'b1;
               err_nx_s    = 1'b1;
            end else begin
               penable_nx_s = 1'b1;
               cnt_nx_s     = cnt_inc_s;
            end
         end
         ST_RESP: begin
            next_s    = ST_IDLE;
            psel_nx_s = {NUM_SLAVES{1'b0}};
         end
         default: begin
            next_s    = ST_IDLE;
            psel_nx_s = {NUM_SLAVES{1'b0}};
         end
      endcase
   end

   // FSM state, timeout counter and registered response/APB control outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         psel_r    <= {NUM_SLAVES{1'b0}};
         penable_r <= 1'b0;
         rvalid_r  <= 1'b0;
         err_r     <= 1'b0;
         rdata_r   <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r   <= next_s;
         cnt_r     <= cnt_nx_s;
         psel_r    <= psel_nx_s;
         penable_r <= penable_nx_s;
         rvalid_r  <= rvalid_nx_s;
         err_r     <= err_nx_s;
         rdata_r   <= rdata_nx_s;
      end
   end

   // Request capture on grant; strobes are forced to zero for reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r   <= {ADDR_WIDTH{1'b0}};
         wdata_r  <= {DATA_WIDTH{1'b0}};
         pstrb_r  <= {BE_WIDTH{1'b0}};
         pwrite_r <= 1'b0;
         index_r  <= {IDXW{1'b0}};
      end else if (latch_s) begin
         addr_r   <= peri_addr;
         wdata_r  <= peri_wdata;
         pstrb_r  <= peri_write ? peri_be : {BE_WIDTH{1'b0}};
         pwrite_r <= peri_write;
         index_r  <= dec_idx_s;
      end
   end

   assign peri_rvalid = rvalid_r;
   assign peri_err    = err_r;
   assign peri_rdata  = rdata_r;
   assign apb_paddr   = addr_r;
   assign apb_pwdata  = wdata_r;
   assign apb_pwrite  = pwrite_r;
   assign apb_pstrb   = pstrb_r;
   assign apb_penable = penable_r;
   assign apb_psel    = psel_r;

endmodule
